// File: rtl/instr_decode.sv
// RV32I decode/issue stage: registers decoded fields, pulses en to the ALU, holds issue across control flow.
// Optional INSTR_COUNT_EN adds a 64-bit retired-instruction counter output (instret).
module instr_decode #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] instrPC,
    input  logic            instrValid,
    output logic            instrReady,
    input  logic            stall,
    input  logic            pcRwEn,
    output logic            en,
    output logic [6:0]      opcode,
    output logic [14:0]     func,
    output logic [XLEN-1:0] imm,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic [11:0]     csrAddr,
    output logic [XLEN-1:0] currentPC,
    output logic            rwEn,
    output logic            illegal,
`ifdef INSTR_COUNT_EN
    output logic [63:0]     instret,
`endif
    output logic            flush
);

    localparam logic [1:0] RUN  = 2'd0;
    localparam logic [1:0] BRW1 = 2'd1;
    localparam logic [1:0] BRW2 = 2'd2;

    localparam logic [4:0] OP_IMM    = 5'b00100;
    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_SYSTEM = 5'b11100;
    localparam logic [4:0] OP_REG    = 5'b01100;

    logic [1:0]      state_q, state_d;
    logic            en_q;
    logic            flush_q, flush_d;
    logic [6:0]      opcode_q;
    logic [14:0]     func_q;
    logic [XLEN-1:0] imm_q, imm_d;
    logic [4:0]      rs1_q, rs2_q, rd_q;
    logic [11:0]     csr_q;
    logic [XLEN-1:0] pc_q;
    logic            rwen_q, rwen_d;
    logic            illegal_q;

    logic [4:0] opc;
    logic       known_op;
    logic       writes_rd;
    logic       legal;
    logic       is_ctrl;
    logic       accept;

    assign opc        = instr[6:2];
    assign instrReady = reset & (state_q == RUN) & ~stall;
    assign accept     = instrValid & instrReady;
    assign is_ctrl    = (opc == OP_BRANCH) | (opc == OP_JAL) | (opc == OP_JALR);

    always_comb begin
        imm_d     = '0;
        known_op  = 1'b1;
        writes_rd = 1'b0;
        case (opc)
            OP_IMM, OP_LOAD, OP_JALR: begin
                imm_d     = {{20{instr[31]}}, instr[31:20]};
                writes_rd = 1'b1;
            end
            OP_STORE:  imm_d = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OP_BRANCH: imm_d = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            OP_LUI, OP_AUIPC: begin
                imm_d     = {instr[31:12], 12'h000};
                writes_rd = 1'b1;
            end
            OP_JAL: begin
                imm_d     = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
                writes_rd = 1'b1;
            end
            OP_SYSTEM: begin
                imm_d     = {20'h00000, instr[31:20]};
                writes_rd = (instr[14:12] != 3'b000);
            end
            OP_REG:    writes_rd = 1'b1;
            default:   known_op  = 1'b0;
        endcase
    end

    // Undecodable words still issue, but must never write the register file.
    assign legal  = known_op & (instr[1:0] == 2'b11);
    assign rwen_d = legal & writes_rd & (instr[11:7] != 5'd0);

    always_comb begin
        state_d = state_q;
        flush_d = 1'b0;
        case (state_q)
            RUN:  if (accept && is_ctrl) state_d = BRW1;
            BRW1: state_d = BRW2;
            BRW2: begin
                state_d = RUN;
                flush_d = pcRwEn;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= RUN;
            en_q      <= 1'b0;
            flush_q   <= 1'b0;
            opcode_q  <= '0;
            func_q    <= '0;
            imm_q     <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rd_q      <= '0;
            csr_q     <= '0;
            pc_q      <= RESET_PC;
            rwen_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            en_q    <= accept;
            flush_q <= flush_d;
            if (accept) begin
                opcode_q  <= instr[6:0];
                func_q    <= {5'b00000, instr[31:25], instr[14:12]};
                imm_q     <= imm_d;
                rs1_q     <= instr[19:15];
                rs2_q     <= instr[24:20];
                rd_q      <= instr[11:7];
                csr_q     <= instr[31:20];
                pc_q      <= instrPC;
                rwen_q    <= rwen_d;
                illegal_q <= ~legal;
            end
        end
    end

`ifdef INSTR_COUNT_EN
    logic [63:0] instret_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            instret_q <= '0;
        end else if (en_q && !illegal_q) begin
            instret_q <= instret_q + 64'd1;
        end
    end

    assign instret = instret_q;
`endif

    assign en        = en_q;
    assign flush     = flush_q;
    assign opcode    = opcode_q;
    assign func      = func_q;
    assign imm       = imm_q;
    assign rs1       = rs1_q;
    assign rs2       = rs2_q;
    assign rd        = rd_q;
    assign csrAddr   = csr_q;
    assign currentPC = pc_q;
    assign rwEn      = rwen_q;
    assign illegal   = illegal_q;

endmodule
